// File: rtl/scratchpad_feature_buffer_pkg.sv
`default_nettype none
//============================================================================
// Module   : scratchpad_feature_buffer_pkg
// Purpose  : Shared types and helpers for the ping-pong feature scratchpad.
//            Holds the bank-state encoding and an index-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
package scratchpad_feature_buffer_pkg;

    // Lifecycle of one bank: loaded, then consumed, then recycled.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam int NUM_BANKS = 2;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scratchpad_feature_buffer_bank.sv
`default_nettype none
//============================================================================
// Module   : scratchpad_feature_buffer_bank
// Purpose  : One bank of TN x DEPTH lines of LINE_W bits with per-line valid
//            bits and a fill counter. One write port, one read port that
//            returns the addressed line of every group at once.
// Ports    : clk, rst          - clock, async active-high reset
//            wr_en_i           - write strobe (already range-checked)
//            wr_group_i/line_i - write address
//            wr_data_i         - write data
//            clr_i             - drop all valid bits and the fill count
//            rd_line_i         - line read from all groups (combinational)
//            rd_data_o         - group g in [g*LINE_W +: LINE_W]
//            fill_done_o       - this write sets the last missing valid bit
// Revision : 1.0 - initial release
//============================================================================
module scratchpad_feature_buffer_bank #(
    parameter int TN     = 4,
    parameter int DEPTH  = 5,
    parameter int LINE_W = 8,
    parameter int GI_W   = 2,
    parameter int LI_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [GI_W-1:0]      wr_group_i,
    input  logic [LI_W-1:0]      wr_line_i,
    input  logic [LINE_W-1:0]    wr_data_i,
    input  logic                 clr_i,
    input  logic [LI_W-1:0]      rd_line_i,
    output logic [TN*LINE_W-1:0] rd_data_o,
    output logic                 fill_done_o
);

    localparam int TOTAL = TN * DEPTH;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TOTAL - 1);

    logic [LINE_W-1:0] mem_q   [TN][DEPTH];
    logic [DEPTH-1:0]  valid_q [TN];
    logic [CNT_W-1:0]  cnt_q;
    logic              w_new_line;

    // Only a 0->1 valid transition advances the count, so rewrites are free.
    assign w_new_line  = ~valid_q[wr_group_i][wr_line_i];
    assign fill_done_o = wr_en_i & w_new_line & (cnt_q == C_LAST);

    // Payload storage needs no reset: the valid bits gate its meaning.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_group_i][wr_line_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < TN; g++) begin
                valid_q[g] <= '0;
            end
            cnt_q <= '0;
        end else if (clr_i) begin
            for (int g = 0; g < TN; g++) begin
                valid_q[g] <= '0;
            end
            cnt_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_group_i][wr_line_i] <= 1'b1;
            if (w_new_line) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < TN; g++) begin : g_rd_grp
            assign rd_data_o[g*LINE_W +: LINE_W] = mem_q[g][rd_line_i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/scratchpad_feature_buffer.sv
`default_nettype none
//============================================================================
// Module   : scratchpad_feature_buffer
// Purpose  : Ping-pong feature scratchpad. The loader fills one bank while
//            the PE array reads all groups of a line from the other; banks
//            swap automatically on fill completion and on release.
// Ports    : clk, rst                     - clock, async active-high reset
//            wr_en_i/group_i/line_i/data_i - line write into the fill bank
//            wr_ready_o                    - fill bank can accept a write
//            rd_en_i, rd_line_i            - read one line of every group
//            rd_data_o, rd_valid_o         - registered read result
//            rd_bank_ready_o               - read bank holds a full tile
//            rd_release_i                  - consumer done with read bank
//            wr_bank_o                     - current fill bank index
//            addr_err_o                    - sticky range/not-ready error
// Revision : 1.0 - initial release
//============================================================================
module scratchpad_feature_buffer
    import scratchpad_feature_buffer_pkg::*;
#(
    parameter int TN      = 4,
    parameter int DEPTH   = 5,
    parameter int LINE_W  = 8,
    parameter int GRP_AW  = 8,
    parameter int LINE_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [GRP_AW-1:0]    wr_group_i,
    input  logic [LINE_AW-1:0]   wr_line_i,
    input  logic [LINE_W-1:0]    wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 rd_en_i,
    input  logic [LINE_AW-1:0]   rd_line_i,
    output logic [TN*LINE_W-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 rd_bank_ready_o,
    input  logic                 rd_release_i,
    output logic                 wr_bank_o,
    output logic                 addr_err_o
);

    localparam int GI_W = idx_w(TN);
    localparam int LI_W = idx_w(DEPTH);
    localparam logic [GRP_AW-1:0]  C_TN    = GRP_AW'(TN);
    localparam logic [LINE_AW-1:0] C_DEPTH = LINE_AW'(DEPTH);

    bank_state_t         state_q [NUM_BANKS];
    bank_state_t         state_d [NUM_BANKS];
    logic                wr_bank_q, wr_bank_d;
    logic                rp_q, rp_d;
    logic [TN*LINE_W-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;

    logic                w_wr_inrange, w_rd_inrange;
    logic                w_wr_acc, w_rd_acc, w_release;
    logic [NUM_BANKS-1:0] w_bank_wr, w_bank_clr, w_fill_done;
    logic [TN*LINE_W-1:0] w_bank_rd [NUM_BANKS];

    assign w_wr_inrange    = (wr_group_i < C_TN) && (wr_line_i < C_DEPTH);
    assign w_rd_inrange    = (rd_line_i < C_DEPTH);
    assign wr_ready_o      = (state_q[wr_bank_q] != BANK_FULL);
    assign rd_bank_ready_o = (state_q[rp_q] == BANK_FULL);
    assign w_wr_acc        = wr_en_i & wr_ready_o & w_wr_inrange;
    assign w_rd_acc        = rd_en_i & rd_bank_ready_o & w_rd_inrange;
    assign w_release       = rd_release_i & rd_bank_ready_o;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_bank_wr[b]  = w_wr_acc & (wr_bank_q == 1'(b));
            assign w_bank_clr[b] = w_release & (rp_q == 1'(b));

            scratchpad_feature_buffer_bank #(
                .TN     (TN),
                .DEPTH  (DEPTH),
                .LINE_W (LINE_W),
                .GI_W   (GI_W),
                .LI_W   (LI_W)
            ) u_bank (
                .clk         (clk),
                .rst         (rst),
                .wr_en_i     (w_bank_wr[b]),
                .wr_group_i  (wr_group_i[GI_W-1:0]),
                .wr_line_i   (wr_line_i[LI_W-1:0]),
                .wr_data_i   (wr_data_i),
                .clr_i       (w_bank_clr[b]),
                .rd_line_i   (rd_line_i[LI_W-1:0]),
                .rd_data_o   (w_bank_rd[b]),
                .fill_done_o (w_fill_done[b])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = w_rd_acc;
        // A write never targets the bank being released (that bank is FULL,
        // which blocks the writer), so both updates can be applied in turn.
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank_wr[b]) begin
                state_d[b] = w_fill_done[b] ? BANK_FULL : BANK_FILLING;
            end
            if (w_bank_clr[b]) begin
                state_d[b] = BANK_EMPTY;
            end
        end
        // fill_done only fires for the bank being written.
        wr_bank_d = wr_bank_q ^ (|w_fill_done);
        rp_d      = rp_q ^ w_release;
        // The read samples the old bank even when released in the same cycle.
        if (w_rd_acc) begin
            rd_data_d = w_bank_rd[rp_q];
        end
        addr_err_d = addr_err_q
                   | (wr_en_i & ~w_wr_inrange)
                   | (rd_en_i & (~rd_bank_ready_o | ~w_rd_inrange));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_EMPTY;
            end
            wr_bank_q  <= 1'b0;
            rp_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rp_q       <= rp_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign wr_bank_o  = wr_bank_q;
    assign addr_err_o = addr_err_q;

endmodule
`default_nettype wire

// File: doc/scratchpad_feature_buffer.md
Name: scratchpad_feature_buffer

Overview:
Double-buffered (ping-pong) successor to the single-bank feature scratchpad. It holds Tn groups × DEPTH lines per bank. The loader writes one line per cycle into the fill bank while the PE array reads all Tn groups of one line in parallel from the other bank. Banks swap automatically on completion, so loading of the next tile overlaps compute on the current one.

Parameters:
Tn, `Tn, number of feature groups (input channels processed in parallel)
DEPTH, `KERNEL_SIZE, lines per group per bank
LINE_W, `DATA_BUS_WIDTH, bits per line (one write beat)
GRP_AW, 8, width of group address
LINE_AW, 4, width of line address

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  write strobe
wr_group  in  GRP_AW  target group
wr_line  in  LINE_AW  target line
wr_data  in  LINE_W  line data
wr_ready  out  1  fill bank can accept a write
rd_en  in  1  read strobe
rd_line  in  LINE_AW  line read from all groups
rd_data  out  Tn*LINE_W  group g in bits [g*LINE_W +: LINE_W]
rd_valid  out  1  rd_data valid (registered)
rd_bank_ready  out  1  read bank holds a complete tile
rd_release  in  1  consumer done with read bank
wr_bank  out  1  index of current fill bank
addr_err  out  1  sticky: out-of-range or not-ready access

Behaviour:
- Reset: async on rst high. All valid bits 0, both banks EMPTY, wr_bank=0, read pointer=0. rd_data=0, rd_valid=0, addr_err=0. wr_ready=1 is the first cycle after deassertion. Reset mid-fill or mid-read discards all contents.
- Per-bank state: EMPTY→FILLING (first accepted write)→FULL (all Tn*DEPTH valid bits set)→EMPTY (release). State is held in 2-bit regs per bank.
- Write accept = wr_en & wr_ready & wr_group<Tn & wr_line<DEPTH. On accept, data is stored and valid[wr_bank][g][l] is set on the next edge.
- Rewriting an already-valid line overwrites the data but does not advance the fill count. The count increments only on a 0→1 valid transition.
- The write that completes the fill sets that bank to FULL on the same edge; wr_bank toggles on that edge.
- wr_ready = state[wr_bank]!=FULL. When the other bank is still FULL (not released), wr_ready stays 0 until release.
- Read pointer rp. rd_bank_ready = state[rp]==FULL.
- Read accept = rd_en & rd_bank_ready & rd_line<DEPTH. Latency is 1: rd_data is registered from line rd_line of all Tn groups of bank rp, and rd_valid=1 the next cycle. With no accept, rd_valid=0 and rd_data holds its last value.
- rd_release with rd_bank_ready: bank rp → EMPTY, its valid bits are cleared, rp toggles. rd_release without rd_bank_ready is ignored.
- rd_en and rd_release in the same cycle: the read is served from the old bank, then the release takes effect.
- Fill completion of bank A in the same cycle as release of bank B: both take effect. The writer moves to B, which is now EMPTY, so wr_ready=1 on the next cycle.
- addr_err is set (sticky until rst) when:
  - wr_en has group/line out of range;
  - rd_en has line out of range;
  - rd_en is asserted without rd_bank_ready.
  These writes/reads are dropped. wr_en while wr_ready=0 is dropped silently, with no error; the producer must honour wr_ready.
- Fill count width: clog2(Tn*DEPTH+1).

Decomposition:
- Shared header (network_para.vh): Tn, KERNEL_SIZE, DATA_BUS_WIDTH, FEATURE_WIDTH; bank-state encodings EMPTY=0, FILLING=1, FULL=2.
- Sub-module feature_bank: one bank of Tn×DEPTH×LINE_W storage with valid bits, write port, all-group read port, clear input and fill counter. Instantiated twice.
- The top level holds the ping-pong pointers, state registers, muxing and error logic.

Test Plan:
- Reset, then fill bank0 with Tn=4, DEPTH=5 (20 writes, data=g*16+l) → wr_bank=1 after the 20th write; rd_bank_ready=1; rd_en line 2 → next cycle rd_valid=1, rd_data groups = 0x02,0x12,0x22,0x32.
- Rewrite (g1,l0) twice during the fill → FULL occurs only after all 20 distinct lines are written; the read returns the last value.
- Fill bank1 while bank0 is unreleased → wr_ready=0 after bank1 is full. Assert rd_release → bank0 EMPTY, wr_ready=1 next cycle, rd_bank_ready stays 1 (now bank1).
- rd_en+rd_release in the same cycle → rd_data from the old bank; rd_bank_ready drops if the other bank is not full.
- Write group 4 or line 5, and rd_en with rd_bank_ready=0 → addr_err=1 and stays set; storage is unchanged.
- Assert rst mid-fill (bank0 at 7/20) → all outputs return to reset values immediately; a subsequent fill needs the full 20 writes.
